conv_output_writer: RTL
=======================

CONV_OUTPUT_WRITER -- requirements
Module: conv_output_writer

Interface
REQ-001 Parameters SHALL be: N, default 8, sample bit width; EngineCount, default 4, engines whose outputs are collected; AddrWidth, default 16, write-address width.
REQ-002 The block SHALL have one clock and an asynchronous active-high reset, listed first in the port list:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
REQ-003 Control ports SHALL be:
- start_i  in  1  begin a layer write-out
- engine_count_i  in  10  active engines, 1..EngineCount
- plane_size_i  in  AddrWidth  words per output plane
- base_addr_i  in  AddrWidth  address of plane 0, pixel 0
REQ-004 Convolution-side ports SHALL be:
- req_next_o  out  1  request the next result vector
- data_i  in  EngineCount x N signed  result vector
- conv_valid_i  in  1  data_i valid
- conv_done_i  in  1  layer finished
REQ-005 Memory-side ports SHALL be:
- wr_en_o  out  1  write strobe
- wr_addr_o  out  AddrWidth  write address
- wr_data_o  out  N  write data
- wr_ready_i  in  1  memory accepts the write this cycle
REQ-006 Status ports SHALL be:
- busy_o  out  1  not IDLE
- done_o  out  1  one-cycle completion pulse
- pixel_count_o  out  AddrWidth  result vectors captured

Function
REQ-007 The FSM SHALL have five states, IDLE, REQUEST, WAIT_VALID, DRAIN and DONE, with IDLE as the reset state.
REQ-008 In IDLE, start_i=1 SHALL clear pixel_count_o and the sticky done flag, then go to REQUEST on the next edge.
REQ-009 REQUEST SHALL drive req_next_o=1 for exactly one cycle, then go to WAIT_VALID.
REQ-010 In WAIT_VALID, conv_valid_i=1 SHALL:
- capture all EngineCount lanes of data_i into a holding register;
- load engine index 0;
- load the address register with base_addr_i + pixel_count_o;
- increment pixel_count_o;
- go to DRAIN.
REQ-011 In DRAIN, wr_en_o SHALL be 1 with wr_data_o = captured lane[index] and wr_addr_o = address register.
REQ-012 In DRAIN, outputs SHALL hold stable while wr_ready_i=0.
REQ-013 In DRAIN, on wr_ready_i=1 the index SHALL increment and the address register SHALL add plane_size_i, so that lane e is written to base + e*plane_size + pixel.
REQ-014 Address arithmetic SHALL wrap modulo 2^AddrWidth, with no multiplier used.
REQ-015 The accepted write of lane engine_count_i-1 SHALL end DRAIN: go to DONE if the done flag is set, otherwise go to REQUEST.
REQ-016 conv_done_i=1 in any non-IDLE state SHALL set the sticky done flag.
REQ-017 conv_done_i=1 in WAIT_VALID with conv_valid_i=0 SHALL go directly to DONE.
REQ-018 If conv_valid_i=1 and conv_done_i=1 occur together in WAIT_VALID, the vector SHALL be captured and drained first, then DONE.
REQ-019 conv_valid_i SHALL be ignored outside WAIT_VALID.
REQ-020 DONE SHALL pulse done_o=1 for one cycle and return to IDLE.
REQ-021 start_i SHALL be ignored outside IDLE.
REQ-022 engine_count_i of 0 SHALL be treated as 1, and values above EngineCount SHALL be clamped to EngineCount.
REQ-023 wr_data_o SHALL be 0 whenever wr_en_o=0.
REQ-024 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-025 rst_i=1 SHALL immediately, at any time including mid-DRAIN, force:
- state to IDLE;
- req_next_o, wr_en_o, done_o and busy_o to 0;
- wr_addr_o, wr_data_o and pixel_count_o to 0;
- the holding register and the sticky done flag to 0.
REQ-026 After reset release, the first start_i SHALL begin a fresh layer with pixel_count_o=0.

Verification
REQ-027 The bench SHALL cover:
- Basic write-out: engine_count=2, plane=9, base=0x100, wr_ready tied 1, three vectors {5,-3},{7,1},{0,2}, then conv_done -> writes (0x100,5),(0x109,-3),(0x101,7),(0x10A,1),(0x102,0),(0x10B,2); done_o one cycle; pixel_count_o=3.
- Backpressure: wr_ready low 3 cycles during lane 1 -> wr_addr_o/wr_data_o held; no duplicate write; req_next_o absent until the drain completes.
- Simultaneous valid+done: final vector {4,4} arrives with conv_done_i -> both lanes written, then done_o; no extra req_next_o.
- Early done: conv_done_i in WAIT_VALID with no valid -> done_o next cycle; zero writes.
- Async reset mid-DRAIN: rst_i asserted between clock edges -> wr_en_o and busy_o drop before the next edge; a new start_i restarts at address base+0.
- Address wrap: base=0xFFFE, plane=1, engine_count=4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.

Source files
------------

// File: rtl/conv_output_writer.sv
// Collects result vectors from the convolution engines and writes each lane to
// its own output plane in memory, one word per cycle, under memory backpressure.
module conv_output_writer #(
    parameter int N           = 8,
    parameter int EngineCount = 4,
    parameter int AddrWidth   = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [9:0]                          engine_count_i,
    input  logic [AddrWidth-1:0]                plane_size_i,
    input  logic [AddrWidth-1:0]                base_addr_i,
    output logic                                req_next_o,
    input  logic signed [EngineCount-1:0][N-1:0] data_i,
    input  logic                                conv_valid_i,
    input  logic                                conv_done_i,
    output logic                                wr_en_o,
    output logic [AddrWidth-1:0]                wr_addr_o,
    output logic [N-1:0]                        wr_data_o,
    input  logic                                wr_ready_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [AddrWidth-1:0]                pixel_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQUEST    = 3'd1,
        ST_WAIT_VALID = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    localparam logic [9:0] ENG_MAX = 10'(EngineCount);

    state_t                       state_r, state_s;
    logic [EngineCount-1:0][N-1:0] hold_r, hold_s;
    logic [9:0]                   idx_r, idx_s;
    logic [AddrWidth-1:0]         addr_r, addr_s;
    logic [AddrWidth-1:0]         pix_r, pix_s;
    logic                         done_flag_r, done_flag_s;
    logic                         req_r, wr_en_r, done_r, busy_r;
    logic [N-1:0]                 wr_data_r, wr_data_s;
    logic [9:0]                   eng_cnt_s;
    logic                         last_lane_s;

    function automatic logic [N-1:0] lane_sel(input logic [EngineCount-1:0][N-1:0] v,
                                              input logic [9:0] i);
        logic [N-1:0] lane;
        lane = '0;
        for (int e = 0; e < EngineCount; e++) begin
            lane = (i == 10'(e)) ? v[e] : lane;
        end
        return lane;
    endfunction

    // Clamp the requested engine count into 1..EngineCount.
    always_comb begin
        eng_cnt_s = engine_count_i;
        if (engine_count_i == 10'd0) begin
            eng_cnt_s = 10'd1;
        end else if (engine_count_i > ENG_MAX) begin
            eng_cnt_s = ENG_MAX;
        end else begin
            eng_cnt_s = engine_count_i;
        end
        last_lane_s = (idx_r == (eng_cnt_s - 10'd1));
    end

    // Next-state and datapath update for the write-out sequencer.
    always_comb begin
        state_s     = state_r;
        hold_s      = hold_r;
        idx_s       = idx_r;
        addr_s      = addr_r;
        pix_s       = pix_r;
        done_flag_s = done_flag_r;
        if ((state_r != ST_IDLE) && conv_done_i) begin
            done_flag_s = 1'b1;
        end else begin
            done_flag_s = done_flag_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    pix_s       = '0;
                    done_flag_s = 1'b0;
                    state_s     = ST_REQUEST;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQUEST: state_s = ST_WAIT_VALID;
            ST_WAIT_VALID: begin
                if (conv_valid_i) begin
                    hold_s  = data_i;
                    idx_s   = 10'd0;
                    addr_s  = base_addr_i + pix_r;
                    pix_s   = pix_r + AddrWidth'(1);
                    state_s = ST_DRAIN;
                end else if (conv_done_i) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT_VALID;
                end
            end
            ST_DRAIN: begin
                if (wr_ready_i && last_lane_s) begin
                    // Flag includes this cycle's conv_done_i so a late done is not lost.
                    state_s = done_flag_s ? ST_DONE : ST_REQUEST;
                end else if (wr_ready_i) begin
                    idx_s  = idx_r + 10'd1;
                    addr_s = addr_r + plane_size_i;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        wr_data_s = (state_s == ST_DRAIN) ? lane_sel(hold_s, idx_s) : '0;
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            hold_r      <= '0;
            idx_r       <= 10'd0;
            addr_r      <= '0;
            pix_r       <= '0;
            done_flag_r <= 1'b0;
            req_r       <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_data_r   <= '0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            hold_r      <= hold_s;
            idx_r       <= idx_s;
            addr_r      <= addr_s;
            pix_r       <= pix_s;
            done_flag_r <= done_flag_s;
            req_r       <= (state_s == ST_REQUEST);
            wr_en_r     <= (state_s == ST_DRAIN);
            wr_data_r   <= wr_data_s;
            done_r      <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign req_next_o    = req_r;
    assign wr_en_o       = wr_en_r;
    assign wr_addr_o     = addr_r;
    assign wr_data_o     = wr_data_r;
    assign done_o        = done_r;
    assign busy_o        = busy_r;
    assign pixel_count_o = pix_r;

endmodule
